// File: rtl/matrix_key_scan.sv
// 4x4 matrix keypad scanner: rotating active-low row drive, per-frame column snapshot,
// frame-level debounce and key commit. Define MATRIX_KEY_RELEASE_FLAG_EN to also flag releases.
module matrix_key_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int SETTLE       = 16,
    parameter int STABLE_SCANS = 20
) (
    input  logic       CLK,
    input  logic       nRST,
    input  logic [3:0] COL,
    output logic [3:0] ROW,
    output logic [3:0] KEY_VALUE,
    output logic       KEY_FLAG,
    output logic       KEY_PRESSED
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(STABLE_SCANS + 1);
    localparam logic [DW-1:0] SETTLE_LAST = DW'(SETTLE - 1);
    localparam logic [DW-1:0] HOLD_LAST   = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_FULL = SW'(STABLE_SCANS);

`ifdef MATRIX_KEY_RELEASE_FLAG_EN
    localparam logic RELEASE_FLAG = 1'b1;
`else
    localparam logic RELEASE_FLAG = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_SETTLE = 4'b0001,
        S_SAMPLE = 4'b0010,
        S_HOLD   = 4'b0100,
        S_EVAL   = 4'b1000
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [DW-1:0]   dwell_cnt;
    logic [1:0]      row_idx;
    logic [3:0]      col_meta;
    logic [3:0]      col_sync;
    logic [15:0]     frame;
    logic [SW-1:0]   stable_cnt;
    logic [SW-1:0]   stable_next;
    logic            prev_hit;
    logic [3:0]      prev_code;

    logic            settle_done;
    logic            row_end;
    logic            do_sample;
    logic            do_eval;

    logic [4:0]      low_count;
    logic            frame_hit;
    logic [3:0]      frame_code;
    logic            commit;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_SETTLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_SETTLE: if (dwell_cnt == SETTLE_LAST) state_next = S_SAMPLE;
            S_SAMPLE: state_next = S_HOLD;
            S_HOLD:   if (dwell_cnt == HOLD_LAST) state_next = (row_idx == 2'd3) ? S_EVAL : S_SETTLE;
            S_EVAL:   state_next = S_SETTLE;
            default:  state_next = S_SETTLE;
        endcase
    end

    always_comb begin
        settle_done = (state == S_SETTLE) && (dwell_cnt == SETTLE_LAST);
        row_end     = (state == S_HOLD) && (dwell_cnt == HOLD_LAST);
        do_sample   = (state == S_SAMPLE);
        do_eval     = (state == S_EVAL);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            col_meta <= 4'b1111;
            col_sync <= 4'b1111;
        end else begin
            col_meta <= COL;
            col_sync <= col_meta;
        end
    end

    // The dwell counter runs across a whole row, so settle + sample + hold is SCAN_DIV clocks.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            dwell_cnt <= '0;
            row_idx   <= 2'd0;
            ROW       <= 4'b1110;
            frame     <= 16'hFFFF;
        end else begin
            if (row_end || do_eval) begin
                dwell_cnt <= '0;
            end else begin
                dwell_cnt <= dwell_cnt + DW'(1);
            end
            if (row_end) begin
                row_idx <= row_idx + 2'd1;
                ROW     <= {ROW[2:0], ROW[3]};
            end
            if (do_sample) begin
                frame[{row_idx, 2'b00} +: 4] <= col_sync;
            end
        end
    end

    // Multiple low bits (ghosting or multi-press) collapse to the released result.
    always_comb begin
        low_count  = 5'd0;
        frame_code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!frame[i]) begin
                low_count  = low_count + 5'd1;
                frame_code = 4'(i);
            end
        end
        frame_hit = (low_count == 5'd1);
        if (!frame_hit) begin
            frame_code = 4'd0;
        end
    end

    always_comb begin
        stable_next = SW'(1);
        if ((frame_hit == prev_hit) && (frame_code == prev_code)) begin
            stable_next = (stable_cnt == STABLE_FULL) ? stable_cnt : stable_cnt + SW'(1);
        end
        commit = (stable_next == STABLE_FULL) && (stable_cnt != STABLE_FULL);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stable_cnt  <= '0;
            prev_hit    <= 1'b0;
            prev_code   <= 4'd0;
            KEY_VALUE   <= 4'd0;
            KEY_PRESSED <= 1'b0;
            KEY_FLAG    <= 1'b0;
        end else begin
            KEY_FLAG <= 1'b0;
            if (do_eval) begin
                stable_cnt <= stable_next;
                prev_hit   <= frame_hit;
                prev_code  <= frame_code;
                if (commit) begin
                    if (frame_hit && (!KEY_PRESSED || (KEY_VALUE != frame_code))) begin
                        KEY_VALUE   <= frame_code;
                        KEY_PRESSED <= 1'b1;
                        KEY_FLAG    <= 1'b1;
                    end else if (!frame_hit && KEY_PRESSED) begin
                        KEY_PRESSED <= 1'b0;
                        KEY_FLAG    <= RELEASE_FLAG;
                    end
                end
            end
        end
    end

endmodule
